// File: rtl/target_compact.sv
// Iterative 256-bit target to 32-bit compact ("nBits") converter: scans leading zero bytes,
// then normalises the mantissa sign bit. Optional inexact flag: TARGET_COMPACT_INEXACT_EN.
module target_compact #(
  parameter int unsigned TARGET_BYTES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8*TARGET_BYTES-1:0] target_in,
  output logic                      busy,
  output logic                      done,
`ifdef TARGET_COMPACT_INEXACT_EN
  output logic                      inexact,
`endif
  output logic [31:0]               compact_out
);

  localparam int unsigned SW = 8 * TARGET_BYTES;
  localparam int unsigned CW = $clog2(TARGET_BYTES + 1);

  typedef enum logic [1:0] {StIdle, StScan, StNorm, StDone} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic [CW-1:0]   size_q, size_d;
  logic [31:0]     compact_q, compact_d;
  logic [23:0]     mant_raw, mant;
  logic [7:0]      exp;
`ifdef TARGET_COMPACT_INEXACT_EN
  logic            inexact_q, inexact_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      size_q    <= '0;
      compact_q <= '0;
`ifdef TARGET_COMPACT_INEXACT_EN
      inexact_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      size_q    <= size_d;
      compact_q <= compact_d;
`ifdef TARGET_COMPACT_INEXACT_EN
      inexact_q <= inexact_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    size_d    = size_q;
    compact_d = compact_q;
`ifdef TARGET_COMPACT_INEXACT_EN
    inexact_d = inexact_q;
`endif
    mant_raw  = sr_q[SW-1 -: 24];
    mant      = mant_raw;
    exp       = 8'(size_q);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sr_d    = target_in;
          size_d  = CW'(TARGET_BYTES);
          state_d = StScan;
        end
      end
      StScan: begin
        if (sr_q[SW-1 -: 8] == 8'h00 && size_q != '0) begin
          sr_d   = sr_q << 8;
          size_d = size_q - 1'b1;
        end else begin
          state_d = StNorm;
        end
      end
      StNorm: begin
        if (size_q == '0) begin
          mant = '0;
          exp  = '0;
        end else if (mant_raw[23]) begin
          // Bit 23 is the compact sign bit, so push the mantissa down one byte.
          mant = {8'h00, mant_raw[23:8]};
          exp  = 8'(size_q) + 8'd1;
        end
        compact_d = {exp, mant};
`ifdef TARGET_COMPACT_INEXACT_EN
        inexact_d = (|sr_q[SW-25:0]) || (mant_raw[23] && (|mant_raw[7:0]));
`endif
        state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q == StScan) || (state_q == StNorm);
  assign done        = (state_q == StDone);
  assign compact_out = compact_q;
`ifdef TARGET_COMPACT_INEXACT_EN
  assign inexact     = inexact_q;
`endif

endmodule

// File: tb/tb_target_compact.sv
// Self-checking bench for target_compact: directed vectors, randomized targets against a
// byte-level reference model, ignored-start and mid-conversion reset scenarios.
module tb_target_compact;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] target_in;
  logic         busy;
  logic         done;
  logic [31:0]  compact_out;
`ifdef TARGET_COMPACT_INEXACT_EN
  logic         inexact;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  target_compact #(.TARGET_BYTES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .target_in  (target_in),
    .busy       (busy),
    .done       (done),
`ifdef TARGET_COMPACT_INEXACT_EN
    .inexact    (inexact),
`endif
    .compact_out(compact_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Number of significant bytes: index of highest nonzero byte plus one.
  function automatic int model_size(input logic [255:0] t);
    int sz = 0;
    for (int i = 0; i < 32; i++) if (t[8*i +: 8] != 8'h00) sz = i + 1;
    return sz;
  endfunction

  function automatic logic [31:0] model_compact(input logic [255:0] t);
    int          sz = model_size(t);
    logic [255:0] v;
    logic [23:0] m;
    if (sz == 0) return 32'h0;
    v = (sz >= 3) ? (t >> (8 * (sz - 3))) : (t << (8 * (3 - sz)));
    m = v[23:0];
    if (m[23]) begin
      m  = m >> 8;
      sz = sz + 1;
    end
    return {8'(sz), m};
  endfunction

  function automatic logic [255:0] expand(input logic [31:0] c);
    int           e = int'(c[31:24]);
    logic [255:0] v = 256'(c[23:0]);
    return (e >= 3) ? (v << (8 * (e - 3))) : (v >> (8 * (3 - e)));
  endfunction

  task automatic run_conv(input string tag, input logic [255:0] t, input bit inject);
    int          k = 0;
    bit          seen = 0;
    logic [31:0] exp_c = model_compact(t);
    int          exp_lat = 3 + (32 - model_size(t));
    @(negedge clk);
    start     = 1'b1;
    target_in = t;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      start     = inject && (k == 2);
      target_in = inject ? ~t : {8{$urandom}};
      if (done) seen = 1;
      else check({tag, "_busy"}, 64'(busy), 64'd1);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(k), 64'(exp_lat));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_compact"}, 64'(compact_out), 64'(exp_c));
`ifdef TARGET_COMPACT_INEXACT_EN
    check({tag, "_inexact"}, 64'(inexact), 64'(expand(exp_c) != t));
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(compact_out), 64'(exp_c));
  endtask

  initial begin
    logic [255:0] t;
    int           z;
    int           pulses;
    rst       = 1'b1;
    start     = 1'b0;
    target_in = '0;
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_compact", 64'(compact_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    t = '0;
    t[223:208] = 16'hFFFF;
    run_conv("genesis", t, 0);
    run_conv("zero", 256'h0, 0);
    run_conv("x80", 256'h80, 0);
    run_conv("x123456", 256'h123456, 0);
    run_conv("x12345678", 256'h12345678, 0);
    run_conv("x12345600", 256'h12345600, 0);
    run_conv("allones", ~256'h0, 0);
    run_conv("ignored_start", 256'h00FF_0000_1234, 1);

    // Reset in the middle of an all-zero scan.
    @(negedge clk);
    start     = 1'b1;
    target_in = '0;
    repeat (3) @(negedge clk) start = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_compact", 64'(compact_out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    run_conv("after_rst", 256'h1D00FFFF_0000, 0);

    for (int n = 0; n < 40; n++) begin
      t = '0;
      for (int i = 0; i < 32; i++) t[8*i +: 8] = 8'($urandom);
      z = $urandom_range(32, 0);
      for (int i = 32 - z; i < 32; i++) t[8*i +: 8] = 8'h00;
      if ($urandom_range(1, 0) == 1)
        for (int i = 0; i < 29 - z; i++) t[8*i +: 8] = 8'h00;
      run_conv("rand", t, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/target_compact.md
Name: target_compact

Overview:
- Converts a 256-bit expanded difficulty target back into the 32-bit compact ("nBits") form: exponent byte, then 3-byte mantissa.
- Inverse of the team's compact-to-256-bit target expander.
- Used by the control and reporting path to publish the current share or block target in header format.
- Iterative: scans one byte per cycle from the MSB, then normalises; start/done handshake.

Parameters:
- TARGET_BYTES, 32, byte width of the expanded target. Fixed at 32 for this design; the scan counter is sized from it.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion; accepted only when busy=0.
- target_in  input  256  expanded target; sampled in the accept cycle only.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse; compact_out is valid in this cycle.
- compact_out  output  32  {exponent[7:0], mantissa[23:0]}; held until the next done.

Behaviour:
- Reset (async, any state): FSM goes to IDLE; busy=0, done=0, compact_out=32'h0; internal shift register and size are cleared.
- FSM states: IDLE, SCAN, NORM, DONE.
- IDLE:
  - On start=1, capture target_in into a 256-bit shift register sr.
  - Set size=32 and busy=1, then go to SCAN.
  - start while busy=1 is ignored (no queueing).
- SCAN, one byte per cycle:
  - If sr[255:248]==0 and size!=0: sr <= sr<<8, size <= size-1, stay in SCAN.
  - Otherwise go to NORM.
  - Left-shifting zero-fills, so for size<3 the mantissa sr[255:232] equals value<<(8*(3-size)) automatically.
- NORM:
  - mant = sr[255:232], exp = size.
  - If size==0: mant=0, exp=0.
  - Else if mant[23]==1 (sign bit in compact form): mant <= {8'h00, mant[23:8]}, exp <= size+1.
  - Go to DONE.
- DONE:
  - compact_out <= {exp, mant}, done=1 for exactly one cycle, busy=0.
  - Return to IDLE; a new start is accepted in the following cycle.
- Latency:
  - Accept at cycle T; z = number of leading zero bytes (0..32).
  - done is asserted at T+3+z.
  - Worst case is the all-zero input: done at T+35.
- Arithmetic:
  - exp is 8 bits; the maximum reachable value is 33 (size 32 plus normalisation), so there is no overflow.
  - Bytes below the mantissa are truncated (round toward zero). The compact result re-expands to a value <= the input.
- Reset mid-conversion: the conversion is aborted, done is not pulsed, and compact_out returns to 0.

Optional Feature:
- Macro: TARGET_COMPACT_INEXACT_EN.
- When defined:
  - Adds output port "inexact" (1 bit), reset 0, updated together with compact_out at DONE.
  - inexact=1 if any nonzero bit was discarded, i.e. |sr[231:0] at NORM entry, or mant[7:0]!=0 when the normalisation shift occurs.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Genesis target 256'h00000000FFFF0000...00 (FFFF at bytes 27..26) -> compact_out=32'h1D00FFFF; z=4, done at T+7; inexact=0.
- target_in=0 -> compact_out=32'h00000000 at T+35; busy=1 for cycles T+1..T+34.
- target_in=256'h80 -> mantissa bit 23 set, normalised -> 32'h02008000. target_in=256'h123456 -> 32'h03123456.
- target_in=256'h12345678 -> 32'h04123456; with TARGET_COMPACT_INEXACT_EN, inexact=1. 256'h12345600 -> inexact=0.
- Pulse start again at T+2 with a different target -> ignored; the first result is unchanged and exactly one done pulse occurs.
- Assert rst at T+3 during an all-zero scan -> busy=0 and compact_out=0 immediately, no done pulse. A fresh start afterwards converts correctly.
